// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//
// Multi-cycle integer divider for the M-extension datapath. It takes one
// request at a time and works out one quotient bit per clock with a restoring
// subtract. It returns the quotient and remainder with a single-cycle done
// pulse. Signed and unsigned division follow RISC-V DIV/DIVU/REM/REMU rules,
// including the divide-by-zero and signed-overflow results.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous reset, active-high
//   i_start        request strobe, accepted only while o_busy = 0
//   i_signed       1 = two's-complement operands, sampled with i_start
//   i_dividend     dividend, sampled with i_start
//   i_divisor      divisor, sampled with i_start
//   o_busy         high from the accepting edge until the cycle after o_done
//   o_done         one-cycle pulse; results are valid then and held afterwards
//   o_quotient     registered quotient
//   o_remainder    registered remainder
//   o_div_by_zero  registered divide-by-zero flag, valid with o_done
//   o_state        current FSM state (IDLE=0, CALC=1, DONE=2), for debug
//
// Handshake: a request is taken on a rising edge where i_start = 1 and
// o_busy = 0. Nothing is queued. i_start is ignored while o_busy = 1. A
// request raised in the first cycle with o_busy = 0 is taken on the next edge,
// so requests can follow each other without a gap.
// ---------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  // Holds the dividend magnitude. Its bits shift out at the top while quotient
  // bits shift in at the bottom. After WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  // The partial remainder always stays below the divisor, so WIDTH bits are
  // enough to store it. The trial subtraction itself is WIDTH+1 bits wide.
  logic [WIDTH-1:0] prem;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             div_zero;
  logic             overflow;
  logic             last_iter;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] prem_step;
  logic [WIDTH-1:0] q_step;

  // Request decode and operand magnitudes.
  always_comb begin
    accept   = (state == IDLE) && i_start;
    div_zero = (i_divisor == '0);
    overflow = i_signed && (i_dividend == MIN_NEG) && (i_divisor == '1);
    a_neg    = i_signed && i_dividend[WIDTH-1];
    b_neg    = i_signed && i_divisor[WIDTH-1];
    // The most negative value maps to itself when negated. Read as unsigned,
    // that is still its correct magnitude.
    a_mag    = a_neg ? (~i_dividend + 1'b1) : i_dividend;
    b_mag    = b_neg ? (~i_divisor + 1'b1) : i_divisor;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder, then try to subtract the divisor.
  always_comb begin
    last_iter = (count == CW'(WIDTH - 1));
    shifted   = {prem, dvd[WIDTH-1]};
    trial     = shifted - {1'b0, dvs};
    q_bit     = ~trial[WIDTH];
    prem_step = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_step    = {dvd[WIDTH-2:0], q_bit};
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (div_zero || overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register. Busy and done are registered from the next state, so both
  // come straight from flops and no input reaches an output combinationally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_next;
      o_busy <= (state_next != IDLE);
      o_done <= (state_next == DONE);
    end
  end

  // Datapath and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count         <= '0;
      dvd           <= '0;
      dvs           <= '0;
      prem          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg_q <= i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            neg_r <= a_neg;
            dvd   <= a_mag;
            dvs   <= b_mag;
            prem  <= '0;
            count <= '0;
            // The two special cases produce their result on the accepting
            // edge. A normal request leaves the old results in place until
            // its own result is ready.
            if (div_zero) begin
              o_quotient    <= '1;
              o_remainder   <= i_dividend;
              o_div_by_zero <= 1'b1;
            end else if (overflow) begin
              o_quotient    <= MIN_NEG;
              o_remainder   <= '0;
              o_div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          prem  <= prem_step;
          dvd   <= q_step;
          count <= count + CW'(1);
          if (last_iter) begin
            o_quotient    <= neg_q ? (~q_step + 1'b1) : q_step;
            o_remainder   <= neg_r ? (~prem_step + 1'b1) : prem_step;
            o_div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//
// Directed self-checking bench for iter_divider. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge. Latency is the
// number of falling edges after the accepting rising edge up to and including
// the first one where o_done is seen high.
// ---------------------------------------------------------------------------
module tb_iter_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_in;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [1:0]  state;

  int checks;
  int errors;

  iter_divider #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_signed      (signed_in),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero),
    .o_state       (state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver task. It issues one request on the next falling edge and waits at
  // most 100 cycles for done. A timeout is reported as lat = -1.
  // acc = the block was idle before the edge and busy just after it.
  // With hold = 1, i_start stays high until done is seen.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic hold, output int lat, output logic acc,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic busy_pre;
    logic seen;
    @(negedge clk);
    signed_in = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    busy_pre  = busy;
    @(posedge clk);
    #1;
    acc = !busy_pre && busy;
    if (!hold) start = 1'b0;
    lat  = -1;
    seen = 1'b0;
    q    = '0;
    r    = '0;
    dz   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat  = i + 1;
        q    = quotient;
        r    = remainder;
        dz   = div_by_zero;
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    signed_in = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_q got %h exp 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_r got %h exp 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", div_by_zero); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
  endtask

  task automatic test_unsigned();
    int lat; logic acc; logic [31:0] q, r; logic dz; int extra;
    // Keep start high the whole time: only one operation may run.
    run_op(1'b0, 32'd100, 32'd7, 1'b1, lat, acc, q, r, dz);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL udiv_acc got %b exp 1", acc); end
    checks++; if (lat != 33) begin errors++; $display("FAIL udiv_lat got %0d exp 33", lat); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL udiv_q got %h exp %h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL udiv_r got %h exp %h", r, 32'd2); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL udiv_dz got %b exp 0", dz); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL udiv_after got done=%b busy=%b exp 0 0", done, busy); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL udiv_no_second got %0d exp 0", extra); end
    checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin errors++; $display("FAIL udiv_hold got %h/%h exp 0000000e/00000002", quotient, remainder); end
  endtask

  task automatic test_signed();
    int lat; logic acc; logic [31:0] q, r; logic dz;
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat, acc, q, r, dz);
    checks++; if (lat != 33) begin errors++; $display("FAIL sdiv1_lat got %0d exp 33", lat); end
    checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv1_q got %h exp fffffffd", q); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv1_r got %h exp ffffffff", r); end
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, lat, acc, q, r, dz);
    checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv2_q got %h exp fffffffd", q); end
    checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL sdiv2_r got %h exp 00000001", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL sdiv2_dz got %b exp 0", dz); end
  endtask

  task automatic test_div_by_zero();
    int lat; logic acc; logic [31:0] q, r; logic dz;
    for (int m = 0; m < 2; m++) begin
      run_op(m[0], 32'h1234_5678, 32'h0, 1'b0, lat, acc, q, r, dz);
      checks++; if (lat != 1) begin errors++; $display("FAIL dz%0d_lat got %0d exp 1", m, lat); end
      checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz%0d_q got %h exp ffffffff", m, q); end
      checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL dz%0d_r got %h exp 12345678", m, r); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz%0d_flag got %b exp 1", m, dz); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz%0d_busy_fall got %b exp 0", m, busy); end
    end
  endtask

  task automatic test_overflow();
    int lat; logic acc; logic [31:0] q, r; logic dz;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, acc, q, r, dz);
    checks++; if (lat != 1) begin errors++; $display("FAIL ovf_lat got %0d exp 1", lat); end
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q got %h exp 80000000", q); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ovf_r got %h exp 00000000", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL ovf_dz got %b exp 0", dz); end
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, acc, q, r, dz);
    checks++; if (lat != 33) begin errors++; $display("FAIL ovfu_lat got %0d exp 33", lat); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL ovfu_q got %h exp 00000000", q); end
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL ovfu_r got %h exp 80000000", r); end
  endtask

  task automatic test_boundary();
    int lat; logic acc; logic [31:0] q, r; logic dz;
    run_op(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, acc, q, r, dz);
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bnd1_q got %h exp ffffffff", q); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL bnd1_r got %h exp 00000000", r); end
    run_op(1'b0, 32'd5, 32'd9, 1'b0, lat, acc, q, r, dz);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL bnd2_q got %h exp 00000000", q); end
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL bnd2_r got %h exp 00000005", r); end
  endtask

  task automatic test_reset_mid();
    int lat; logic acc; logic [31:0] q, r; logic dz; int pulses;
    @(negedge clk);
    signed_in = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
    checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin errors++; $display("FAIL rmid_res got %h/%h exp 0/0", quotient, remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_dz got %b exp 0", div_by_zero); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d exp 0", state); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", pulses); end
    run_op(1'b0, 32'd42, 32'd6, 1'b0, lat, acc, q, r, dz);
    checks++; if (lat != 33) begin errors++; $display("FAIL rmid_new_lat got %0d exp 33", lat); end
    checks++; if (q !== 32'd7 || r !== 32'd0) begin errors++; $display("FAIL rmid_new_res got %h/%h exp 00000007/00000000", q, r); end
  endtask

  task automatic test_back_to_back();
    int lat; logic acc; logic [31:0] q, r; logic dz;
    run_op(1'b0, 32'd1000, 32'd10, 1'b0, lat, acc, q, r, dz);
    checks++; if (acc !== 1'b1 || q !== 32'd100 || r !== 32'd0) begin errors++; $display("FAIL b2b_a got acc=%b %h/%h exp 1 00000064/00000000", acc, q, r); end
    run_op(1'b1, 32'hFFFF_FF9C, 32'h0, 1'b0, lat, acc, q, r, dz);
    checks++; if (acc !== 1'b1 || lat != 1) begin errors++; $display("FAIL b2b_b_acc got acc=%b lat=%0d exp 1 1", acc, lat); end
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FF9C || dz !== 1'b1) begin errors++; $display("FAIL b2b_b_res got %h/%h dz=%b exp ffffffff/ffffff9c 1", q, r, dz); end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, acc, q, r, dz);
    checks++; if (acc !== 1'b1 || lat != 1) begin errors++; $display("FAIL b2b_c_acc got acc=%b lat=%0d exp 1 1", acc, lat); end
    checks++; if (q !== 32'h8000_0000 || r !== 32'h0 || dz !== 1'b0) begin errors++; $display("FAIL b2b_c_res got %h/%h dz=%b exp 80000000/00000000 0", q, r, dz); end
    run_op(1'b0, 32'd81, 32'd9, 1'b0, lat, acc, q, r, dz);
    checks++; if (acc !== 1'b1 || lat != 33) begin errors++; $display("FAIL b2b_d_acc got acc=%b lat=%0d exp 1 33", acc, lat); end
    checks++; if (q !== 32'd9 || r !== 32'd0) begin errors++; $display("FAIL b2b_d_res got %h/%h exp 00000009/00000000", q, r); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
